uart_apb_host: RTL and testbench
================================

Name: uart_apb_host

Overview:
- APB3 initiator that drives one CoreUARTapb register file on behalf of a streaming client.
- After reset it programs the baud and frame settings from parameters.
- It then polls the status register continuously. It moves received bytes to an RX valid/ready stream and bytes from a TX valid/ready stream into the transmit data register.
- It sits between a fabric byte-stream producer/consumer and the UART's APB slave port, so software is not needed for UART traffic.

Parameters:
- BAUD_VAL, 0, 13-bit baud divisor; bits [7:0] go to CTRL1, bits [12:8] go to CTRL2[7:3].
- BIT8, 1, value written to CTRL2[0] (8-bit data).
- PARITY_EN, 0, value written to CTRL2[1].
- ODD_N_EVEN, 0, value written to CTRL2[2].
- FRAC_EN, 0, 1 = also write CTRL3 during configuration.
- BAUD_FRAC, 0, 3-bit fractional baud value written to CTRL3[2:0] when FRAC_EN=1.

Ports:
- PCLK  in  1  system clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PADDR  out  5  APB address; register offsets 0x00/0x04/0x08/0x0C/0x10/0x14.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  1 = write.
- PWDATA  out  8  write data.
- PRDATA  in  8  read data; sampled in the access phase when PREADY=1.
- PREADY  in  1  slave ready; access phase extends while low.
- PSLVERR  in  1  slave error; sampled with PREADY.
- TX_DATA  in  8  byte to transmit; must be held stable while TX_VALID=1.
- TX_VALID  in  1  TX byte available.
- TX_READY  out  1  one-cycle pulse: byte accepted (its APB write completed).
- RX_DATA  out  8  received byte.
- RX_VALID  out  1  RX_DATA valid; held until RX_READY.
- RX_READY  in  1  consumer accepts RX_DATA.
- ERR  out  4  sticky flags {bus_err, framing, overflow, parity}.
- ERR_CLR  in  1  clears ERR.
- CFG_DONE  out  1  high once configuration writes have completed.

Behaviour:
- Reset (PRESET=1 at an edge) zeroes all outputs: PSEL, PENABLE, PWRITE, PADDR, PWDATA, TX_READY, RX_VALID, RX_DATA, ERR and CFG_DONE. The FSM enters CFG1.
- Reset during an active transfer drops PSEL/PENABLE at that edge. Nothing in flight is completed or acknowledged.
- APB transfer format:
  - SETUP cycle: PSEL=1, PENABLE=0, with PADDR/PWRITE/PWDATA registered.
  - ACCESS cycles: PENABLE=1, held with all signals stable until PREADY=1.
  - After the completing edge, PSEL=0 and PENABLE=0 for at least one cycle. There are no back-to-back transfers.
  - Minimum transfer length is 2 cycles plus 1 idle cycle.
- FSM states: CFG1, CFG2, CFG3, POLL, RXRD, TXWR. Each state performs exactly one APB transfer, then takes the listed transition.
  - CFG1: write 0x08 = BAUD_VAL[7:0]. Then go to CFG2.
  - CFG2: write 0x0C = {BAUD_VAL[12:8], ODD_N_EVEN, PARITY_EN, BIT8}. Then go to CFG3 if FRAC_EN=1, else POLL. CFG_DONE is set on completion when FRAC_EN=0.
  - CFG3: write 0x14 = {5'b0, BAUD_FRAC}. CFG_DONE is set on completion. Then go to POLL.
  - POLL: read 0x10. Status bit 0 = TXRDY, bit 1 = RXRDY, bit 2 = parity, bit 3 = overflow, bit 4 = framing.
    - Go to RXRD if RXRDY=1 and RX_VALID=0.
    - Otherwise go to TXWR if TXRDY=1 and TX_VALID=1.
    - Otherwise stay in POLL.
    - RX has priority over TX.
  - RXRD: read 0x04. On completion RX_DATA <= PRDATA and RX_VALID <= 1. Then go to POLL.
  - TXWR: PWDATA <= TX_DATA, captured at SETUP. On completion TX_READY=1 for exactly that cycle. Then go to POLL.
- Every data transfer is preceded by a fresh status read. No TX write is issued without a TXRDY=1 observed after the previous TX write.
- RX backpressure: while RX_VALID=1 and RX_READY=0, no RXRD is issued and TX traffic continues. RX_VALID clears on a cycle with RX_READY=1.
- The RX buffer is single-entry. The RXRD completion cycle always sees RX_VALID=0, so no overwrite can occur.
- ERR:
  - bits [2:0] OR in status bits {4,3,2} at each POLL completion.
  - bit 3 sets on any completion with PSLVERR=1. That transfer is still treated as complete and the FSM advances normally.
  - ERR_CLR clears ERR. If a set and ERR_CLR occur in the same cycle, the set wins.
- TX_VALID dropping before acceptance is a client protocol violation. If it drops before TXWR is entered, no write is issued.

Test Plan:
- Reset, then PREADY=1 with BAUD_VAL=0x1A5, BIT8=1, PARITY_EN=1, ODD_N_EVEN=1, FRAC_EN=1, BAUD_FRAC=3 -> writes in order: 0x08=0xA5, 0x0C=0x0F, 0x14=0x03. CFG_DONE rises on the third completion, then the first POLL read to 0x10 follows.
- Status=0x01 and TX_VALID with TX_DATA=0x55 -> write 0x00=0x55 and a single TX_READY pulse. Next status=0x00 keeps TX_VALID=0x66 pending with no write until status returns 0x01.
- Status=0x03 with TX_VALID=1 and PRDATA(0x04)=0xC3 -> RX read first, RX_DATA=0xC3 and RX_VALID=1, then on the next POLL the TX write.
- Hold RX_READY=0 with status=0x02 repeated -> no further 0x04 reads. Raise RX_READY -> RX_VALID clears, then the next POLL issues a 0x04 read.
- PREADY low for 3 access cycles on a TX write -> PSEL/PENABLE/PADDR/PWDATA stay stable for 4 access cycles. PSLVERR=1 at completion -> ERR=0x8. ERR_CLR with status=0x10 in the same cycle -> ERR=0x4.
- Assert PRESET in the ACCESS phase of the CFG2 write -> next cycle PSEL=0 and all outputs are zero. Sequence restarts at CFG1 with 0x08.

Source files
------------

// File: rtl/uart_apb_host.sv
// uart_apb_host: APB3 initiator that configures a CoreUARTapb register file
// and then shuttles bytes between valid/ready streams and the UART by
// polling its status register.
module uart_apb_host #(
    parameter logic [12:0] BAUD_VAL   = 13'd0,
    parameter logic        BIT8       = 1'b1,
    parameter logic        PARITY_EN  = 1'b0,
    parameter logic        ODD_N_EVEN = 1'b0,
    parameter logic        FRAC_EN    = 1'b0,
    parameter logic [2:0]  BAUD_FRAC  = 3'd0
) (
    input  logic       PCLK,
    input  logic       PRESET,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic [3:0] ERR,
    input  logic       ERR_CLR,
    output logic       CFG_DONE
);

    // CoreUARTapb register offsets
    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_CTRL3  = 5'h14;

    // Which register operation the next/current APB transfer performs
    typedef enum logic [2:0] {
        ST_CFG1 = 3'd0,
        ST_CFG2 = 3'd1,
        ST_CFG3 = 3'd2,
        ST_POLL = 3'd3,
        ST_RXRD = 3'd4,
        ST_TXWR = 3'd5
    } state_t;

    // Where we are inside one APB transfer; IDLE is the mandatory gap cycle
    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } phase_t;

    state_t     state_r, state_s;
    phase_t     phase_r, phase_s;
    logic [4:0] paddr_r, paddr_s;
    logic       psel_r, psel_s;
    logic       penable_r, penable_s;
    logic       pwrite_r, pwrite_s;
    logic [7:0] pwdata_r, pwdata_s;
    logic       tx_ready_r, tx_ready_s;
    logic [7:0] rx_data_r, rx_data_s;
    logic       rx_valid_r, rx_valid_s;
    logic [3:0] err_r, err_s;
    logic       cfg_done_r, cfg_done_s;

    // Next-state and next-output computation for the transfer sequencer
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        paddr_s    = paddr_r;
        psel_s     = psel_r;
        penable_s  = penable_r;
        pwrite_s   = pwrite_r;
        pwdata_s   = pwdata_r;
        tx_ready_s = 1'b0;
        rx_data_s  = rx_data_r;
        cfg_done_s = cfg_done_r;

        // Consumer handshake frees the single-entry RX buffer
        if (rx_valid_r && RX_READY) begin
            rx_valid_s = 1'b0;
        end else begin
            rx_valid_s = rx_valid_r;
        end

        // Clear first so that a same-cycle set below takes precedence
        if (ERR_CLR) begin
            err_s = 4'b0000;
        end else begin
            err_s = err_r;
        end

        case (phase_r)
            PH_IDLE: begin
                // Launch the SETUP cycle for the transfer this state owns
                phase_s   = PH_SETUP;
                psel_s    = 1'b1;
                penable_s = 1'b0;
                case (state_r)
                    ST_CFG1: begin
                        paddr_s  = ADDR_CTRL1;
                        pwrite_s = 1'b1;
                        pwdata_s = BAUD_VAL[7:0];
                    end
                    ST_CFG2: begin
                        paddr_s  = ADDR_CTRL2;
                        pwrite_s = 1'b1;
                        pwdata_s = {BAUD_VAL[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
                    end
                    ST_CFG3: begin
                        paddr_s  = ADDR_CTRL3;
                        pwrite_s = 1'b1;
                        pwdata_s = {5'b00000, BAUD_FRAC};
                    end
                    ST_RXRD: begin
                        paddr_s  = ADDR_RXDATA;
                        pwrite_s = 1'b0;
                        pwdata_s = 8'h00;
                    end
                    ST_TXWR: begin
                        // Byte is captured here and held through ACCESS
                        paddr_s  = ADDR_TXDATA;
                        pwrite_s = 1'b1;
                        pwdata_s = TX_DATA;
                    end
                    default: begin
                        paddr_s  = ADDR_STATUS;
                        pwrite_s = 1'b0;
                        pwdata_s = 8'h00;
                    end
                endcase
            end
            PH_SETUP: begin
                phase_s   = PH_ACCESS;
                penable_s = 1'b1;
            end
            PH_ACCESS: begin
                if (PREADY) begin
                    // Completing edge: release the bus and act on the result
                    phase_s   = PH_IDLE;
                    psel_s    = 1'b0;
                    penable_s = 1'b0;
                    err_s[3]  = err_s[3] | PSLVERR;
                    case (state_r)
                        ST_CFG1: begin
                            state_s = ST_CFG2;
                        end
                        ST_CFG2: begin
                            if (FRAC_EN) begin
                                state_s = ST_CFG3;
                            end else begin
                                state_s    = ST_POLL;
                                cfg_done_s = 1'b1;
                            end
                        end
                        ST_CFG3: begin
                            state_s    = ST_POLL;
                            cfg_done_s = 1'b1;
                        end
                        ST_POLL: begin
                            err_s[2:0] = err_s[2:0] | PRDATA[4:2];
                            // RX wins over TX; RX only when the buffer is free
                            if (PRDATA[1] && !rx_valid_r) begin
                                state_s = ST_RXRD;
                            end else if (PRDATA[0] && TX_VALID) begin
                                state_s = ST_TXWR;
                            end else begin
                                state_s = ST_POLL;
                            end
                        end
                        ST_RXRD: begin
                            rx_data_s  = PRDATA;
                            rx_valid_s = 1'b1;
                            state_s    = ST_POLL;
                        end
                        ST_TXWR: begin
                            tx_ready_s = 1'b1;
                            state_s    = ST_POLL;
                        end
                        default: begin
                            state_s = ST_POLL;
                        end
                    endcase
                end else begin
                    phase_s = PH_ACCESS;
                end
            end
            default: begin
                phase_s   = PH_IDLE;
                psel_s    = 1'b0;
                penable_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r    <= ST_CFG1;
            phase_r    <= PH_IDLE;
            paddr_r    <= 5'h00;
            psel_r     <= 1'b0;
            penable_r  <= 1'b0;
            pwrite_r   <= 1'b0;
            pwdata_r   <= 8'h00;
            tx_ready_r <= 1'b0;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            err_r      <= 4'b0000;
            cfg_done_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            paddr_r    <= paddr_s;
            psel_r     <= psel_s;
            penable_r  <= penable_s;
            pwrite_r   <= pwrite_s;
            pwdata_r   <= pwdata_s;
            tx_ready_r <= tx_ready_s;
            rx_data_r  <= rx_data_s;
            rx_valid_r <= rx_valid_s;
            err_r      <= err_s;
            cfg_done_r <= cfg_done_s;
        end
    end

    assign PADDR    = paddr_r;
    assign PSEL     = psel_r;
    assign PENABLE  = penable_r;
    assign PWRITE   = pwrite_r;
    assign PWDATA   = pwdata_r;
    assign TX_READY = tx_ready_r;
    assign RX_DATA  = rx_data_r;
    assign RX_VALID = rx_valid_r;
    assign ERR      = err_r;
    assign CFG_DONE = cfg_done_r;

endmodule

// File: tb/tb_uart_apb_host.sv
// tb_uart_apb_host: table-driven bench acting as the APB slave and the
// stream client; each row describes one expected APB transfer.
module tb_uart_apb_host;

    logic       pclk;
    logic       preset;
    logic [4:0] paddr;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [3:0] err;
    logic       err_clr;
    logic       cfg_done;

    int checks = 0;
    int errors = 0;

    uart_apb_host #(
        .BAUD_VAL   (13'h1A5),
        .BIT8       (1'b1),
        .PARITY_EN  (1'b1),
        .ODD_N_EVEN (1'b1),
        .FRAC_EN    (1'b1),
        .BAUD_FRAC  (3'd3)
    ) dut (
        .PCLK     (pclk),
        .PRESET   (preset),
        .PADDR    (paddr),
        .PSEL     (psel),
        .PENABLE  (penable),
        .PWRITE   (pwrite),
        .PWDATA   (pwdata),
        .PRDATA   (prdata),
        .PREADY   (pready),
        .PSLVERR  (pslverr),
        .TX_DATA  (tx_data),
        .TX_VALID (tx_valid),
        .TX_READY (tx_ready),
        .RX_DATA  (rx_data),
        .RX_VALID (rx_valid),
        .RX_READY (rx_ready),
        .ERR      (err),
        .ERR_CLR  (err_clr),
        .CFG_DONE (cfg_done)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [4:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         waits;
        logic       slverr;
        logic       eclr;
        logic       txv;
        logic [7:0] txd;
        logic       rxr;
        logic       e_txr;
        logic       e_rxv;
        logic [7:0] e_rxd;
        logic [3:0] e_err;
        logic       e_cfg;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] a, input logic w, input logic [7:0] wd,
                       input logic [7:0] rd, input int wt, input logic se, input logic ec,
                       input logic tv, input logic [7:0] td, input logic rr,
                       input logic etr, input logic erv, input logic [7:0] erd,
                       input logic [3:0] ee, input logic ecf);
        vec_t v;
        v.addr = a;   v.wr = w;     v.wdata = wd;  v.rdata = rd;  v.waits = wt;
        v.slverr = se; v.eclr = ec; v.txv = tv;    v.txd = td;    v.rxr = rr;
        v.e_txr = etr; v.e_rxv = erv; v.e_rxd = erd; v.e_err = ee; v.e_cfg = ecf;
        vq.push_back(v);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " psel"},     {7'd0, psel},     8'h00);
        chk({tag, " penable"},  {7'd0, penable},  8'h00);
        chk({tag, " pwrite"},   {7'd0, pwrite},   8'h00);
        chk({tag, " paddr"},    {3'd0, paddr},    8'h00);
        chk({tag, " pwdata"},   pwdata,           8'h00);
        chk({tag, " tx_ready"}, {7'd0, tx_ready}, 8'h00);
        chk({tag, " rx_valid"}, {7'd0, rx_valid}, 8'h00);
        chk({tag, " rx_data"},  rx_data,          8'h00);
        chk({tag, " err"},      {4'd0, err},      8'h00);
        chk({tag, " cfg_done"}, {7'd0, cfg_done}, 8'h00);
    endtask

    // Wait for SETUP, check it, serve the access phase, check the result
    task automatic xfer(input vec_t v, input int idx);
        bit    found;
        string t;
        t = $sformatf("v%0d", idx);
        found = 1'b0;
        for (int n = 0; n < 32; n++) begin
            if (psel === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(posedge pclk); #1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s setup: got no PSEL expected transfer to 0x%0h", t, v.addr);
            return;
        end
        chk({t, " setup penable"}, {7'd0, penable}, 8'h00);
        chk({t, " paddr"},  {3'd0, paddr},  {3'd0, v.addr});
        chk({t, " pwrite"}, {7'd0, pwrite}, {7'd0, v.wr});
        if (v.wr) chk({t, " pwdata"}, pwdata, v.wdata);
        pready = 1'b0;
        for (int w = 0; w <= v.waits; w++) begin
            @(posedge pclk); #1;
            chk($sformatf("%s acc%0d psel", t, w),    {7'd0, psel},    8'h01);
            chk($sformatf("%s acc%0d penable", t, w), {7'd0, penable}, 8'h01);
            chk($sformatf("%s acc%0d paddr", t, w),   {3'd0, paddr},   {3'd0, v.addr});
            if (v.wr) chk($sformatf("%s acc%0d pwdata", t, w), pwdata, v.wdata);
            if (w == v.waits) begin
                pready  = 1'b1;
                prdata  = v.rdata;
                pslverr = v.slverr;
                err_clr = v.eclr;
            end else begin
                pready = 1'b0;
            end
        end
        @(posedge pclk); #1;
        pready  = 1'b0;
        pslverr = 1'b0;
        err_clr = 1'b0;
        prdata  = 8'h00;
        chk({t, " idle psel"},    {7'd0, psel},     8'h00);
        chk({t, " idle penable"}, {7'd0, penable},  8'h00);
        chk({t, " tx_ready"},     {7'd0, tx_ready}, {7'd0, v.e_txr});
        chk({t, " rx_valid"},     {7'd0, rx_valid}, {7'd0, v.e_rxv});
        chk({t, " rx_data"},      rx_data,          v.e_rxd);
        chk({t, " err"},          {4'd0, err},      {4'd0, v.e_err});
        chk({t, " cfg_done"},     {7'd0, cfg_done}, {7'd0, v.e_cfg});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t cfg1;
        bit   found;
        preset = 1'b1; prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check_zero("reset");
        preset = 1'b0;

        //  addr   wr    wdata  rdata  wt se  ec    txv  txd    rxr   etr  erv  erd    err   cfg
        add(5'h08, 1'b1, 8'hA5, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
        add(5'h0C, 1'b1, 8'h0F, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
        add(5'h14, 1'b1, 8'h03, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        add(5'h10, 1'b0, 8'h00, 8'h01, 0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        add(5'h00, 1'b1, 8'h55, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1);
        add(5'h10, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        add(5'h10, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        add(5'h10, 1'b0, 8'h00, 8'h01, 0, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        add(5'h00, 1'b1, 8'h66, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1);
        add(5'h10, 1'b0, 8'h00, 8'h03, 0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        add(5'h04, 1'b0, 8'h00, 8'hC3, 0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'hC3, 4'h0, 1'b1);
        add(5'h10, 1'b0, 8'h00, 8'h03, 0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'hC3, 4'h0, 1'b1);
        add(5'h00, 1'b1, 8'h77, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 8'hC3, 4'h0, 1'b1);
        add(5'h10, 1'b0, 8'h00, 8'h02, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC3, 4'h0, 1'b1);
        add(5'h10, 1'b0, 8'h00, 8'h02, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC3, 4'h0, 1'b1);
        add(5'h04, 1'b0, 8'h00, 8'h5A, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 4'h0, 1'b1);
        add(5'h10, 1'b0, 8'h00, 8'h01, 0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h5A, 4'h0, 1'b1);
        add(5'h00, 1'b1, 8'h3C, 8'h00, 3, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h5A, 4'h8, 1'b1);
        add(5'h10, 1'b0, 8'h00, 8'h10, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 4'h4, 1'b1);
        add(5'h10, 1'b0, 8'h00, 8'h0C, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 4'h7, 1'b1);

        foreach (vq[i]) begin
            tx_valid = vq[i].txv;
            tx_data  = vq[i].txd;
            rx_ready = vq[i].rxr;
            xfer(vq[i], i);
        end

        // Reset from idle clears sticky state, then CFG1 restarts
        preset = 1'b1;
        @(posedge pclk); #1;
        check_zero("reset2");
        preset = 1'b0;
        cfg1 = vq[0];
        xfer(cfg1, 100);

        // Reset in the ACCESS phase of the CFG2 write
        found = 1'b0;
        for (int n = 0; n < 32; n++) begin
            if (psel === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(posedge pclk); #1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL cfg2 setup: got no PSEL expected transfer to 0x0c");
        end
        chk("cfg2 paddr", {3'd0, paddr}, 8'h0C);
        @(posedge pclk); #1;
        chk("cfg2 penable", {7'd0, penable}, 8'h01);
        preset = 1'b1;
        pready = 1'b1;
        @(posedge pclk); #1;
        check_zero("midreset");
        preset = 1'b0;
        pready = 1'b0;
        xfer(cfg1, 101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
